// File: rtl/dual_port_ram_be_if.sv
// dual_port_ram_be_if: two-port request/response bundle plus the clear-engine busy status
interface dual_port_ram_be_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int BYTE_WIDTH = 8
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;
    logic                  en_a, en_b;
    logic                  we_a, we_b;
    logic [NB-1:0]         be_a, be_b;
    logic [ADDR_WIDTH-1:0] addr_a, addr_b;
    logic [DATA_WIDTH-1:0] data_a, data_b;
    logic [DATA_WIDTH-1:0] q_a, q_b;
    logic                  valid_a, valid_b;
    logic                  busy;
    modport master (
        output en_a, en_b, we_a, we_b, be_a, be_b, addr_a, addr_b, data_a, data_b,
        input  q_a, q_b, valid_a, valid_b, busy
    );
    modport slave (
        input  en_a, en_b, we_a, we_b, be_a, be_b, addr_a, addr_b, data_a, data_b,
        output q_a, q_b, valid_a, valid_b, busy
    );
endinterface

// File: rtl/dual_port_ram_be.sv
// dual_port_ram_be: byte-enable true dual-port RAM with clear engine; DPRAM_COLLISION_DETECT_EN adds a sticky collision flag
module dual_port_ram_be #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 6,
    parameter int                    BYTE_WIDTH  = 8,
    parameter int                    OUT_REG     = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     reset,
`ifdef DPRAM_COLLISION_DETECT_EN
    output logic                     collision,
`endif
    dual_port_ram_be_if.slave        bus
);
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    typedef enum logic {CLEAR, READY} state_t;
    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  acc_a, acc_b;
    logic [NB-1:0]         wm_a, wm_b;
    logic [DATA_WIDTH-1:0] rd_a, rd_b, q1_a, q1_b;
    logic                  v1_a, v1_b;
    assign acc_a = bus.en_a && state == READY;
    assign acc_b = bus.en_b && state == READY;
    assign wm_a  = (acc_a && bus.we_a) ? bus.be_a : '0;
    assign wm_b  = (acc_b && bus.we_b) ? bus.be_b : '0;
    // each port sees the pre-cycle word overlaid only with its own written lanes
    always_comb begin
        rd_a = mem[bus.addr_a];
        rd_b = mem[bus.addr_b];
        for (int i = 0; i < NB; i++) begin
            rd_a[i*BYTE_WIDTH +: BYTE_WIDTH] = wm_a[i] ? bus.data_a[i*BYTE_WIDTH +: BYTE_WIDTH] : rd_a[i*BYTE_WIDTH +: BYTE_WIDTH];
            rd_b[i*BYTE_WIDTH +: BYTE_WIDTH] = wm_b[i] ? bus.data_b[i*BYTE_WIDTH +: BYTE_WIDTH] : rd_b[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end
    // port A is written last so it owns overlapping lanes
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) mem[ptr] <= CLEAR_VALUE;
            else for (int i = 0; i < NB; i++) begin
                if (wm_b[i]) mem[bus.addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
                if (wm_a[i]) mem[bus.addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            ptr      <= '0;
            bus.busy <= 1'b1;
        end else if (state == CLEAR) begin
            ptr      <= ptr + 1'b1;
            state    <= &ptr ? READY : CLEAR;
            bus.busy <= ~&ptr;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            q1_a <= '0;
            q1_b <= '0;
            v1_a <= 1'b0;
            v1_b <= 1'b0;
        end else begin
            v1_a <= acc_a;
            v1_b <= acc_b;
            if (acc_a) q1_a <= rd_a;
            if (acc_b) q1_b <= rd_b;
        end
    end
    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] q2_a, q2_b;
            logic                  v2_a, v2_b;
            always_ff @(posedge clk) begin
                if (reset) begin
                    q2_a <= '0;
                    q2_b <= '0;
                    v2_a <= 1'b0;
                    v2_b <= 1'b0;
                end else begin
                    q2_a <= q1_a;
                    q2_b <= q1_b;
                    v2_a <= v1_a;
                    v2_b <= v1_b;
                end
            end
            assign bus.q_a     = q2_a;
            assign bus.q_b     = q2_b;
            assign bus.valid_a = v2_a;
            assign bus.valid_b = v2_b;
        end else begin : g_direct
            assign bus.q_a     = q1_a;
            assign bus.q_b     = q1_b;
            assign bus.valid_a = v1_a;
            assign bus.valid_b = v1_b;
        end
    endgenerate
`ifdef DPRAM_COLLISION_DETECT_EN
    always_ff @(posedge clk) begin
        if (reset) collision <= 1'b0;
        else if (acc_a && acc_b && bus.addr_a == bus.addr_b && (|wm_a || |wm_b)) collision <= 1'b1;
    end
`endif
endmodule

// File: doc/dual_port_ram_be.md
# dual_port_ram_be

Parametrised successor to the single-clock true dual-port RAM. It adds per-port enables, byte-enable writes, defined mixed-port collision behaviour, an optional output register stage and a post-reset clear engine that initialises every word. It sits wherever a two-master shared buffer is needed, and each port's read data is tagged with a valid strobe.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH
- ADDR_WIDTH, 6, address width; depth = 2**ADDR_WIDTH
- BYTE_WIDTH, 8, bits per byte lane; NB = DATA_WIDTH/BYTE_WIDTH
- OUT_REG, 0, 0 = read latency 1, 1 = extra output register, latency 2
- CLEAR_VALUE, 0, word written to every location by the clear engine
- clk  input  1  single clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- en_a / en_b  input  1  port access request
- we_a / we_b  input  1  write qualifier; effective only with en_x
- be_a / be_b  input  NB  byte-lane write enables
- addr_a / addr_b  input  ADDR_WIDTH  word address
- data_a / data_b  input  DATA_WIDTH  write data
- q_a / q_b  output  DATA_WIDTH  read data
- valid_a / valid_b  output  1  q_x carries data for an accepted access
- busy  output  1  clear engine active; port requests ignored
- collision  output  1  sticky mixed-port same-address flag (only with the macro below)

## Operation
- FSM states: CLEAR and READY. Reset forces CLEAR, sets the clear pointer to 0, and clears all pipeline valids.
- CLEAR: writes CLEAR_VALUE to mem[ptr] each cycle and increments ptr. When ptr = 2**ADDR_WIDTH-1 has been written, the next state is READY. busy=1 throughout CLEAR; en_a/en_b are ignored and produce no valid.
- READY: busy=0. An accepted access is en_x=1.
- Write: lanes with be_x[i]=1 are updated. we_x=1 with be_x=0 is a read.
- Every accepted access, read or write, returns data on q_x with valid_x.
- Same-port read-during-write: returns new data, i.e. the old word merged with the written lanes.
- Mixed-port, same address, same cycle:
  - Both writing: overlapping lanes take port A's data. Non-overlapping lanes take their own port's data.
  - One port reading while the other writes: the reader gets old data, i.e. the pre-cycle contents of the address.
  - Both reading: both get the same word.
- q_x holds its last value when no access is accepted. valid_x pulses 1 cycle per accepted access.
- Reset mid-clear restarts the clear from address 0. Reset in READY discards in-flight reads (valids drop) and re-clears the whole memory.

## Timing
- Reset values: q_a=q_b=0, valid_a=valid_b=0, busy=1, collision=0.
- busy stays 1 for 2**ADDR_WIDTH cycles after the cycle reset deasserts. The first accepted access is in the cycle busy reads 0.
- Read latency with OUT_REG=0: access at edge N, q/valid valid after edge N+1. With OUT_REG=1: after edge N+2.
- Back-to-back accesses sustain one per port per cycle with no bubbles.
- A write at edge N is visible to a read on either port accepted at edge N+1.

## Configuration
- DPRAM_COLLISION_DETECT_EN defined: the collision port exists.
  - It is set at the edge following any accepted same-address access pair where at least one port writes.
  - It is sticky until reset.
- DPRAM_COLLISION_DETECT_EN undefined: the collision port and its logic are absent. Data behaviour is unchanged.

## Test plan
- Clear after reset: ADDR_WIDTH=4, CLEAR_VALUE=32'hA5A5A5A5 -> busy high for exactly 16 cycles; reads of addresses 0..15 all return 32'hA5A5A5A5.
- Byte-enable write: write 32'h11223344 to addr 3, then port B writes 32'hFFFFFFFF with be_b=4'b0101 to addr 3 -> read returns 32'h11FF33FF, valid after 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1).
- Dual write collision: A writes 32'hAAAAAAAA with be=4'b0011 and B writes 32'hBBBBBBBB with be=4'b0110, both to addr 7 -> mem[7] low lanes = 32'h??BBAAAA, i.e. lane2=BB, lane1=AA, lane0=AA, lane3 unchanged; collision=1 when the macro is defined.
- Mixed read/write: mem[5]=1; A writes 2 to addr 5 while B reads addr 5 -> q_b=1, q_a=2; the next B read returns 2.
- Reset mid-clear: assert reset at clear ptr=9 -> busy stays high for the full 2**ADDR_WIDTH cycles after release; valids stay 0 while busy.
- Request during busy: en_a=1, we_a=1 to addr 0 during CLEAR -> no valid_a; mem[0] = CLEAR_VALUE after clear.
